// File: rtl/dnn_batch_scorer_if.sv
// Bundle between the batch scorer, its run/abort controller, the stimulus memory and one DNN core.
// The master side drives control and DNN results; the slave side is the scorer.
`timescale 1ns/1ps
interface dnn_batch_scorer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLASSES = 10,
   parameter int LABEL_WIDTH = 8,
   parameter int CNT_WIDTH   = 16
) ();
   logic                              run;
   logic                              abort;
   logic [CNT_WIDTH-1:0]              num_tc;
   logic                              next_tc;
   logic [LABEL_WIDTH-1:0]            exp_y;
   logic                              dnn_start;
   logic                              dnn_done;
   logic                              dnn_reset;
   logic [NUM_CLASSES*DATA_WIDTH-1:0] dnn_out;
   logic                              busy;
   logic                              done;
   logic                              aborted;
   logic [LABEL_WIDTH-1:0]            pred_class;
   logic                              pred_valid;
   logic [CNT_WIDTH-1:0]              tc_count;
   logic [CNT_WIDTH-1:0]              hit_count;

   modport master (
      output run, abort, num_tc, exp_y, dnn_done, dnn_out,
      input  next_tc, dnn_start, dnn_reset, busy, done, aborted,
             pred_class, pred_valid, tc_count, hit_count
   );

   modport slave (
      input  run, abort, num_tc, exp_y, dnn_done, dnn_out,
      output next_tc, dnn_start, dnn_reset, busy, done, aborted,
             pred_class, pred_valid, tc_count, hit_count
   );
endinterface

// File: rtl/dnn_batch_scorer.sv
// Batch accuracy controller: runs num_tc cases through one DNN core, takes a serial
// argmax of the signed scores and counts cases and correct predictions.
//
// state  | meaning
// IDLE   | waiting for run
// NEXT   | advance stimulus memory (next_tc)
// SETTLE | memory data and exp_y settle
// START  | kick the DNN core (dnn_start)
// WAIT   | wait for a dnn_done rising edge
// SCAN   | one class compared per cycle
// SCORE  | publish prediction, update counts
// CLEAR  | clear the DNN core (dnn_reset); loop or finish
// FIN    | batch finished (done)
`timescale 1ns/1ps
module dnn_batch_scorer #(
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLASSES = 10,
   parameter int LABEL_WIDTH = 8,
   parameter int CNT_WIDTH   = 16
) (
   input logic               clk,
   input logic               rst,
   dnn_batch_scorer_if.slave bus
);
   localparam int IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_NEXT, S_SETTLE, S_START, S_WAIT, S_SCAN, S_SCORE, S_CLEAR, S_FIN
   } state_t;

   state_t                        state;
   state_t                        nxt;
   logic                          dnn_done_q;
   logic                          abort_pend;
   logic [CNT_WIDTH-1:0]          num_lat;
   logic [IW-1:0]                 idx;
   logic signed [DATA_WIDTH-1:0]  best_val;
   logic [LABEL_WIDTH-1:0]        best_cls;
   logic signed [DATA_WIDTH-1:0]  score [NUM_CLASSES];
   logic signed [DATA_WIDTH-1:0]  score_cur;
   logic                          scan_gt;
   logic                          scan_last;
   logic                          done_rise;
   logic                          take_abort;
   logic [LABEL_WIDTH-1:0]        cls_nxt;

   always_comb begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
         score[i] = bus.dnn_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Running best starts at (0, class 0), so class 0 means no positive score.
   always_comb begin
      score_cur  = score[idx];
      scan_gt    = score_cur > best_val;
      cls_nxt    = scan_gt ? (LABEL_WIDTH'(idx) + LABEL_WIDTH'(1)) : best_cls;
      scan_last  = (idx == IW'(NUM_CLASSES - 1));
      done_rise  = bus.dnn_done & ~dnn_done_q;
      take_abort = bus.abort && (state != S_IDLE) && (state != S_CLEAR) && (state != S_FIN);
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:   if (bus.run) nxt = (bus.num_tc == '0) ? S_FIN : S_NEXT;
         S_NEXT:   nxt = S_SETTLE;
         S_SETTLE: nxt = S_START;
         S_START:  nxt = S_WAIT;
         S_WAIT:   if (done_rise) nxt = S_SCAN;
         S_SCAN:   if (scan_last) nxt = S_SCORE;
         S_SCORE:  nxt = S_CLEAR;
         S_CLEAR:  nxt = (abort_pend || (bus.tc_count == num_lat)) ? S_FIN : S_NEXT;
         S_FIN:    nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
      if (take_abort) nxt = S_CLEAR;
   end

   // Outputs are registered from the next state, so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         dnn_done_q     <= 1'b0;
         abort_pend     <= 1'b0;
         num_lat        <= '0;
         idx            <= '0;
         best_val       <= '0;
         best_cls       <= '0;
         bus.next_tc    <= 1'b0;
         bus.dnn_start  <= 1'b0;
         bus.dnn_reset  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.aborted    <= 1'b0;
         bus.pred_class <= '0;
         bus.pred_valid <= 1'b0;
         bus.tc_count   <= '0;
         bus.hit_count  <= '0;
      end else begin
         state          <= nxt;
         dnn_done_q     <= bus.dnn_done;
         bus.next_tc    <= (nxt == S_NEXT);
         bus.dnn_start  <= (nxt == S_START);
         bus.dnn_reset  <= (nxt == S_CLEAR);
         bus.busy       <= (nxt != S_IDLE);
         bus.done       <= (nxt == S_FIN);
         bus.pred_valid <= (state == S_SCAN) && (nxt == S_SCORE);

         if ((state == S_IDLE) && bus.run) begin
            num_lat       <= bus.num_tc;
            bus.tc_count  <= '0;
            bus.hit_count <= '0;
            bus.aborted   <= 1'b0;
            abort_pend    <= 1'b0;
         end

         if (take_abort) abort_pend <= 1'b1;

         if (state == S_WAIT) begin
            idx      <= '0;
            best_val <= '0;
            best_cls <= '0;
         end

         if (state == S_SCAN) begin
            idx      <= idx + IW'(1);
            best_cls <= cls_nxt;
            if (scan_gt) best_val <= score_cur;
            if (nxt == S_SCORE) bus.pred_class <= cls_nxt;
         end

         if (state == S_SCORE) begin
            bus.tc_count <= bus.tc_count + CNT_WIDTH'(1);
            if (best_cls == bus.exp_y) bus.hit_count <= bus.hit_count + CNT_WIDTH'(1);
         end

         if ((state == S_CLEAR) && (nxt == S_FIN) && abort_pend) bus.aborted <= 1'b1;
         if (state == S_FIN) abort_pend <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dnn_batch_scorer.sv
// Scoreboard bench for dnn_batch_scorer: stimulus pushes expected predictions and batch
// summaries; a monitor pops and compares on pred_valid and done.
`timescale 1ns/1ps
module tb_dnn_batch_scorer;
   localparam int DW = 8;
   localparam int NC = 10;
   localparam int LW = 8;
   localparam int CW = 16;

   typedef struct {
      int tc;
      int hit;
      int ab;
      int n;
   } bexp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dnn_batch_scorer_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .LABEL_WIDTH(LW), .CNT_WIDTH(CW)) bus ();

   dnn_batch_scorer #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .LABEL_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Hand-computed cases: scores, expected label, predicted class
   int case_sc [8][NC] = '{
      '{0, 5, -3, 20, 1, 0, 0, 0, 0, 0},
      '{-1, -5, 0, -128, -3, 0, -2, -7, 0, -1},
      '{0, 0, 7, 0, 0, 0, 7, 0, 0, 0},
      '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
      '{127, 0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{-128, -1, -2, -3, 0, 50, 0, 0, 0, 0},
      '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3},
      '{1, -1, -1, -1, -1, -1, -1, -1, -1, 2}
   };
   int case_y    [8] = '{4, 0, 3, 10, 2, 6, 1, 0};
   int case_pred [8] = '{4, 0, 3, 10, 1, 6, 1, 10};

   int    vectors = 0;
   int    miscompares = 0;
   int    exp_pred_q [$];
   bexp_t exp_b_q [$];
   int    n_next, n_start, n_reset;
   int    mem_base = 0;
   int    mem_ptr;
   int    dnn_lat = 3;
   int    dnn_cnt;

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got timeout, required event", name);
   endtask

   // Stimulus memory: next_tc presents the next case of the current batch
   always @(negedge clk) begin
      logic [NC*DW-1:0] v;
      if (!rst || !bus.busy) begin
         mem_ptr = 0;
         if (!rst) begin
            bus.dnn_out = '0;
            bus.exp_y   = '0;
         end
      end else if (bus.next_tc) begin
         v = '0;
         for (int i = 0; i < NC; i++) v[i*DW +: DW] = 8'(case_sc[mem_base + mem_ptr][i]);
         bus.dnn_out = v;
         bus.exp_y   = LW'(case_y[mem_base + mem_ptr]);
         mem_ptr++;
      end
   end

   // DNN core model: done level rises dnn_lat cycles after start, drops on dnn_reset
   always @(negedge clk) begin
      if (!rst) begin
         bus.dnn_done = 1'b0;
         dnn_cnt = 0;
      end else if (bus.dnn_reset) begin
         bus.dnn_done = 1'b0;
         dnn_cnt = 0;
      end else if (bus.dnn_start) begin
         dnn_cnt = dnn_lat;
      end else if (dnn_cnt > 0) begin
         dnn_cnt--;
         if (dnn_cnt == 0) bus.dnn_done = 1'b1;
      end
   end

   // Monitor
   always @(negedge clk) begin
      int    p;
      bexp_t b;
      if (!rst) begin
         n_next = 0; n_start = 0; n_reset = 0;
      end else begin
         if (bus.next_tc)   n_next++;
         if (bus.dnn_start) n_start++;
         if (bus.dnn_reset) n_reset++;
         if (bus.pred_valid) begin
            if (exp_pred_q.size() == 0) timeout("pred_unexpected");
            else begin
               p = exp_pred_q.pop_front();
               check("pred_class", int'(bus.pred_class), p);
            end
         end
         if (bus.done) begin
            if (exp_b_q.size() == 0) timeout("done_unexpected");
            else begin
               b = exp_b_q.pop_front();
               check("tc_count", int'(bus.tc_count), b.tc);
               check("hit_count", int'(bus.hit_count), b.hit);
               check("aborted", int'(bus.aborted), b.ab);
               check("next_tc_pulses", n_next, b.n);
               check("dnn_start_pulses", n_start, b.n);
               check("dnn_reset_pulses", n_reset, b.n);
            end
            n_next = 0; n_start = 0; n_reset = 0;
         end
      end
   end

   task automatic start_batch(input int n, input int base);
      @(negedge clk);
      mem_base   = base;
      bus.num_tc = CW'(n);
      bus.run    = 1'b1;
      @(negedge clk);
      bus.run    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int k = 0; k < budget && !bus.done; k++) @(negedge clk);
      if (!bus.done) timeout(name);
   endtask

   task automatic wait_starts(input int n, input int budget);
      for (int k = 0; k < budget && n_start < n; k++) @(negedge clk);
      if (n_start < n) timeout("wait_dnn_start");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_next_tc"}, int'(bus.next_tc), 0);
      check({tag, "_dnn_start"}, int'(bus.dnn_start), 0);
      check({tag, "_dnn_reset"}, int'(bus.dnn_reset), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_aborted"}, int'(bus.aborted), 0);
      check({tag, "_pred_class"}, int'(bus.pred_class), 0);
      check({tag, "_pred_valid"}, int'(bus.pred_valid), 0);
      check({tag, "_tc_count"}, int'(bus.tc_count), 0);
      check({tag, "_hit_count"}, int'(bus.hit_count), 0);
   endtask

   initial begin
      bus.run = 1'b0; bus.abort = 1'b0; bus.num_tc = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // Single case with cycle-exact start sequence
      exp_pred_q.push_back(case_pred[0]);
      exp_b_q.push_back('{tc: 1, hit: 1, ab: 0, n: 1});
      start_batch(1, 0);
      check("c1_next_tc", int'(bus.next_tc), 1);
      check("c1_busy", int'(bus.busy), 1);
      @(negedge clk);
      check("c2_next_tc", int'(bus.next_tc), 0);
      check("c2_dnn_start", int'(bus.dnn_start), 0);
      @(negedge clk);
      check("c3_dnn_start", int'(bus.dnn_start), 1);
      wait_done("done_single", 200);

      // Non-positive scores and a tie
      exp_pred_q.push_back(case_pred[1]);
      exp_pred_q.push_back(case_pred[2]);
      exp_b_q.push_back('{tc: 2, hit: 2, ab: 0, n: 2});
      start_batch(2, 1);
      wait_done("done_pair", 300);

      // Five-case batch, three hits, with an ignored run mid-batch
      for (int i = 3; i < 8; i++) exp_pred_q.push_back(case_pred[i]);
      exp_b_q.push_back('{tc: 5, hit: 3, ab: 0, n: 5});
      start_batch(5, 3);
      wait_starts(2, 200);
      @(negedge clk);
      bus.num_tc = CW'(1);
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      wait_done("done_batch5", 600);

      // Empty batch: done in the cycle right after run is sampled
      exp_b_q.push_back('{tc: 0, hit: 0, ab: 0, n: 0});
      start_batch(0, 0);
      check("empty_done", int'(bus.done), 1);
      check("empty_next_tc", int'(bus.next_tc), 0);
      wait_done("done_empty", 5);

      // Abort in WAIT on the third case
      dnn_lat = 40;
      exp_pred_q.push_back(case_pred[3]);
      exp_pred_q.push_back(case_pred[4]);
      exp_b_q.push_back('{tc: 2, hit: 1, ab: 1, n: 3});
      start_batch(5, 3);
      wait_starts(3, 400);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_dnn_reset", int'(bus.dnn_reset), 1);
      check("abort_done_early", int'(bus.done), 0);
      @(negedge clk);
      check("abort_done", int'(bus.done), 1);
      check("abort_aborted", int'(bus.aborted), 1);
      wait_done("done_abort", 2);
      @(negedge clk);
      check("aborted_held", int'(bus.aborted), 1);
      check("busy_after_abort", int'(bus.busy), 0);
      dnn_lat = 3;

      // Reset while scanning, then a clean run
      start_batch(1, 0);
      for (int k = 0; k < 100 && !bus.dnn_done; k++) @(negedge clk);
      if (!bus.dnn_done) timeout("wait_dnn_done");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("rst_scan");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_pred_q.push_back(case_pred[0]);
      exp_b_q.push_back('{tc: 1, hit: 1, ab: 0, n: 1});
      start_batch(1, 0);
      wait_done("done_after_rst", 200);

      repeat (3) @(negedge clk);
      check("pred_q_left", exp_pred_q.size(), 0);
      check("batch_q_left", exp_b_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
